// File: rtl/wire_delay_line_if.sv
// -----------------------------------------------------------------------------
// wire_delay_line_if
//
// Purpose:
//   Bundles the control, input and output signals of wire_delay_line into one
//   interface. The stimulus side uses the master modport. The delay line itself
//   uses the slave modport.
//
// Parameters:
//   WIDTH  data bus width in bits (>=1)
//   DEPTH  number of pipeline stages to c_out (>=1)
//   TCW    toggle counter width
//
// Signals (direction as seen by the slave / delay line):
//   en          in   1            advance the pipeline this cycle
//   flush       in   1            synchronous clear of all valid bits
//   a_in        in   WIDTH        input data
//   a_valid     in   1            a_in carries valid data
//   b_out       out  WIDTH        stage-0 data
//   b_valid     out  1            stage-0 valid
//   c_out       out  WIDTH        last-stage data
//   c_valid     out  1            last-stage valid
//   fill        out  FW           count of valid stages, 0..DEPTH
//   toggle_cnt  out  TCW          data-change count
// -----------------------------------------------------------------------------
interface wire_delay_line_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int TCW   = 8
);
    localparam int FW = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] a_in;
    logic             a_valid;
    logic [WIDTH-1:0] b_out;
    logic             b_valid;
    logic [WIDTH-1:0] c_out;
    logic             c_valid;
    logic [FW-1:0]    fill;
    logic [TCW-1:0]   toggle_cnt;

    modport master (
        output en,
        output flush,
        output a_in,
        output a_valid,
        input  b_out,
        input  b_valid,
        input  c_out,
        input  c_valid,
        input  fill,
        input  toggle_cnt
    );

    modport slave (
        input  en,
        input  flush,
        input  a_in,
        input  a_valid,
        output b_out,
        output b_valid,
        output c_out,
        output c_valid,
        output fill,
        output toggle_cnt
    );
endinterface

// File: rtl/wire_delay_line.sv
// -----------------------------------------------------------------------------
// wire_delay_line
//
// Purpose:
//   A parametrised delay and fanout element. A WIDTH-bit bus enters on a_in. It
//   leaves on two taps:
//     b_out - stage 0, one enabled edge after capture
//     c_out - stage DEPTH-1, DEPTH enabled edges after capture
//   Each stage carries a valid bit. The block also keeps a count of occupied
//   stages (fill) and, optionally, a saturating count of data changes
//   (toggle_cnt).
//
// Optional feature:
//   WIRE_TOGGLE_CNT_EN - when this macro is defined, the toggle counter is
//   built. When it is undefined, toggle_cnt is tied to 0. The port list is the
//   same in both builds.
//
// Ports:
//   clk  in  1                      rising-edge clock
//   rst  in  1                      asynchronous reset, active-high
//   bus  wire_delay_line_if.slave   en/flush/a_in/a_valid in;
//                                   b_out/b_valid/c_out/c_valid/fill/
//                                   toggle_cnt out
//
// All outputs are driven straight from registers. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module wire_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int TCW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    wire_delay_line_if.slave      bus
);
    localparam int FW = $clog2(DEPTH + 1);

    // Per-stage state
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;

    // flush overrides en: the stages do not shift and nothing is captured.
    logic advance;
    assign advance = bus.en & ~bus.flush;

    // -------------------------------------------------------------------------
    // Stage next-state logic.
    // Data shifts on every advancing edge, whether or not it is valid. A flush
    // clears only the valid bits. The data registers keep their values, so
    // b_out and c_out still show the old contents, marked invalid.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] src_data;
            logic             src_valid;

            if (gi == 0) begin : g_head
                assign src_data  = bus.a_in;
                assign src_valid = bus.a_valid;
            end else begin : g_body
                assign src_data  = data_q[gi-1];
                assign src_valid = valid_q[gi-1];
            end

            assign data_d[gi]  = advance ? src_data : data_q[gi];
            assign valid_d[gi] = bus.flush ? 1'b0
                               : (bus.en ? src_valid : valid_q[gi]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Occupancy.
    // Fill is incremental: +1 when a valid word enters, -1 when a valid word
    // leaves the last stage. The count already includes the last stage's valid
    // bit, so the subtraction cannot go below zero. The sum is one bit wider so
    // that "+1" at fill==DEPTH cannot wrap before the matching "-1" is applied.
    // -------------------------------------------------------------------------
    logic [FW:0] fill_sum;
    assign fill_sum = {1'b0, fill_q}
                    + {{FW{1'b0}}, bus.a_valid}
                    - {{FW{1'b0}}, valid_q[DEPTH-1]};

    always_comb begin
        fill_d = fill_q;
        if (bus.flush) begin
            fill_d = '0;
        end else if (bus.en) begin
            fill_d = fill_sum[FW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
            fill_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fill_q  <= fill_d;
        end
    end

    // -------------------------------------------------------------------------
    // Toggle counter (optional).
    // A change is counted against the value b_out currently shows, which is the
    // word captured on the last advancing edge. The counter saturates at its
    // maximum value. It is cleared only by rst; flush does not clear it.
    // -------------------------------------------------------------------------
`ifdef WIRE_TOGGLE_CNT_EN
    logic [TCW-1:0] toggle_q;
    logic [TCW-1:0] toggle_d;

    always_comb begin
        toggle_d = toggle_q;
        if (advance && bus.a_valid && (bus.a_in != data_q[0])
                && (toggle_q != {TCW{1'b1}})) begin
            toggle_d = toggle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign bus.toggle_cnt = toggle_q;
`else
    assign bus.toggle_cnt = {TCW{1'b0}};
`endif

    // Registered output taps. When DEPTH is 1, both taps are the same stage.
    assign bus.b_out   = data_q[0];
    assign bus.b_valid = valid_q[0];
    assign bus.c_out   = data_q[DEPTH-1];
    assign bus.c_valid = valid_q[DEPTH-1];
    assign bus.fill    = fill_q;

endmodule
